// File: rtl/pwm4_shadow_if.sv
// rtl/pwm4_shadow_if.sv - duty offer handshake between a duty source (master) and pwm4_shadow (slave)
interface pwm4_shadow_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH:0] DUTY;
    logic           DUTY_VALID;
    logic           DUTY_READY;

    modport master (output DUTY, output DUTY_VALID, input DUTY_READY);
    modport slave  (input DUTY, input DUTY_VALID, output DUTY_READY);
endinterface

// File: rtl/pwm4_shadow.sv
// rtl/pwm4_shadow.sv - shadow-buffered PWM generator driven by an external free-running counter
// Optional complementary output with dead time: define PWM4_COMP_EN.
module pwm4_shadow #(
    parameter int WIDTH    = 4,
    parameter int PCNT_W   = 8,
    parameter int DEADTIME = 1
) (
    input  logic              CLK,
    input  logic              ASYNCRESETN,
    input  logic [WIDTH-1:0]  CNT,
    input  logic              WRAP,
    pwm4_shadow_if.slave      duty_if,
    output logic              PWM,
    output logic [PCNT_W-1:0] PERIOD_CNT,
    output logic              SYNC_ERR
`ifdef PWM4_COMP_EN
    ,
    output logic              PWM_N
`endif
);

    localparam logic [WIDTH:0]   FULL_SCALE = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;

    if (DEADTIME < 0 || DEADTIME > 3) begin : g_bad_deadtime
        $error("pwm4_shadow: DEADTIME must be within 0..3");
    end

    typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WIDTH:0]    active_q, active_d;
    logic [WIDTH:0]    shadow_q, shadow_d;
    logic              shadow_full_q, shadow_full_d;
    logic              pwm_q, pwm_d;
    logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;
    logic              sync_err_q, sync_err_d;
    logic              duty_ready;
    logic              accept;
    logic              commit;
    logic [WIDTH:0]    duty_sat;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_SYNC && WRAP) begin
            state_d = ST_RUN;
        end
    end

    // Compare uses pre-edge state/CNT/active duty, so PWM lags CNT by one cycle.
    always_comb begin
        duty_ready   = !shadow_full_q || WRAP;
        pwm_d        = (state_q == ST_RUN) && ({1'b0, CNT} < active_q);
        period_cnt_d = period_cnt_q;
        if (WRAP && state_q == ST_RUN) begin
            period_cnt_d = period_cnt_q + 1'b1;
        end
        sync_err_d   = sync_err_q || (WRAP && CNT != CNT_MAX);
    end

    // A commit and an accept on the same boundary edge chain shadow -> active, DUTY -> shadow.
    always_comb begin
        duty_sat      = (duty_if.DUTY > FULL_SCALE) ? FULL_SCALE : duty_if.DUTY;
        accept        = duty_if.DUTY_VALID && duty_ready;
        commit        = WRAP && shadow_full_q;
        active_d      = commit ? shadow_q : active_q;
        shadow_d      = accept ? duty_sat : shadow_q;
        shadow_full_d = accept || (shadow_full_q && !commit);
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            pwm_q         <= 1'b0;
            period_cnt_q  <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            pwm_q         <= pwm_d;
            period_cnt_q  <= period_cnt_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign duty_if.DUTY_READY = duty_ready;
    assign PWM                = pwm_q;
    assign PERIOD_CNT         = period_cnt_q;
    assign SYNC_ERR           = sync_err_q;

`ifdef PWM4_COMP_EN
    localparam logic [1:0] DT = 2'(DEADTIME);

    logic [1:0] dead_q, dead_d;
    logic       pwm_n_q, pwm_n_d;

    // Every PWM transition restarts the dead window; a phase shorter than it keeps PWM_N low.
    always_comb begin
        dead_d = dead_q;
        if (pwm_d != pwm_q) begin
            dead_d = DT;
        end else if (dead_q != 2'd0) begin
            dead_d = dead_q - 2'd1;
        end
        pwm_n_d = (state_q == ST_RUN) && !pwm_d && (dead_d == 2'd0);
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            dead_q  <= 2'd0;
            pwm_n_q <= 1'b0;
        end else begin
            dead_q  <= dead_d;
            pwm_n_q <= pwm_n_d;
        end
    end

    assign PWM_N = pwm_n_q;
`endif

endmodule

// File: tb/tb_pwm4_shadow.sv
// tb/tb_pwm4_shadow.sv - directed self-checking bench for pwm4_shadow
module tb_pwm4_shadow;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN;
    logic [3:0] CNT;
    logic       WRAP;
    logic       PWM;
    logic [7:0] PERIOD_CNT;
    logic       SYNC_ERR;
`ifdef PWM4_COMP_EN
    logic       PWM_N;
`endif

    pwm4_shadow_if #(.WIDTH(4)) duty_if ();

    pwm4_shadow #(.WIDTH(4), .PCNT_W(8), .DEADTIME(1)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .CNT         (CNT),
        .WRAP        (WRAP),
        .duty_if     (duty_if),
        .PWM         (PWM),
        .PERIOD_CNT  (PERIOD_CNT),
`ifdef PWM4_COMP_EN
        .PWM_N       (PWM_N),
`endif
        .SYNC_ERR    (SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         highs  = 0;
    int         waits;
    logic       m_run;
    logic [4:0] m_duty;
    logic [4:0] next_duty;
    logic [7:0] m_period;
    logic       m_err;
    logic       m_pwm_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        m_run      = 1'b0;
        m_duty     = 5'd0;
        next_duty  = 5'd0;
        m_period   = 8'd0;
        m_err      = 1'b0;
        m_pwm_prev = 1'b0;
    endtask

    // One clock: advance the external counter and check the registered outputs.
    task automatic tick();
        logic [3:0] pc;
        logic       pw;
        logic       exp_pwm;
        logic       exp_pwm_n;
        pc        = CNT;
        pw        = WRAP;
        exp_pwm   = m_run && ({1'b0, pc} < m_duty);
        exp_pwm_n = m_run && !exp_pwm && !m_pwm_prev;
        @(posedge CLK);
        if (ASYNCRESETN) begin
            if (pw && m_run) m_period++;
            if (pw && pc != 4'd15) m_err = 1'b1;
            if (pw) begin
                m_run  = 1'b1;
                m_duty = next_duty;
            end
        end else begin
            exp_pwm   = 1'b0;
            exp_pwm_n = 1'b0;
        end
        m_pwm_prev = exp_pwm;
        #1;
        CNT  = CNT + 4'd1;
        WRAP = (CNT == 4'd15);
        #1;
        if (PWM === 1'b1) highs++;
        check("pwm", PWM, exp_pwm);
        check("period_cnt", PERIOD_CNT, m_period);
        check("sync_err", SYNC_ERR, m_err);
`ifdef PWM4_COMP_EN
        check("pwm_n", PWM_N, exp_pwm_n);
        check("pwm_overlap", PWM & PWM_N, 1'b0);
`endif
    endtask

    task automatic tick_to(input logic [3:0] v);
        for (int n = 0; n < 40 && CNT != v; n++) tick();
    endtask

    task automatic offer(input logic [4:0] d, input logic [4:0] eff, output int w);
        duty_if.DUTY       = d;
        duty_if.DUTY_VALID = 1'b1;
        w = 0;
        while (duty_if.DUTY_READY !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check("offer_ready", duty_if.DUTY_READY, 1'b1);
        tick();
        next_duty          = eff;
        duty_if.DUTY_VALID = 1'b0;
    endtask

    task automatic count_period(input string tag, input int exp_highs);
        highs = 0;
        repeat (16) tick();
        check(tag, highs, exp_highs);
    endtask

    initial begin
        clear_model();
        ASYNCRESETN        = 1'b1;
        CNT                = 4'd7;
        WRAP               = 1'b0;
        duty_if.DUTY       = 5'd0;
        duty_if.DUTY_VALID = 1'b0;
        #1 ASYNCRESETN = 1'b0;
        #1;
        check("reset_pwm", PWM, 1'b0);
        check("reset_period", PERIOD_CNT, 8'd0);
        check("reset_sync_err", SYNC_ERR, 1'b0);
        check("reset_ready", duty_if.DUTY_READY, 1'b1);
        repeat (4) tick();
        check("reset_ready_run", duty_if.DUTY_READY, 1'b1);

        // Release mid-period; DUTY=5 waits in the shadow until the first wrap.
        ASYNCRESETN = 1'b1;
        offer(5'd5, 5'd5, waits);
        check("first_offer_waits", waits, 0);
        check("ready_full", duty_if.DUTY_READY, 1'b0);
        tick_to(4'd15);
        check("ready_at_wrap", duty_if.DUTY_READY, 1'b1);
        tick();
        check("sync_to_run_period", PERIOD_CNT, 8'd0);
        count_period("duty5_p1", 5);
        count_period("duty5_p2", 5);
        check("period_after_two", PERIOD_CNT, 8'd2);

        // Extremes and saturation.
        offer(5'd0, 5'd0, waits);
        tick_to(4'd0);
        count_period("duty0", 0);
        offer(5'd16, 5'd16, waits);
        tick_to(4'd0);
        count_period("duty16", 16);
        offer(5'd0, 5'd0, waits);
        tick_to(4'd0);
        offer(5'd31, 5'd16, waits);
        tick_to(4'd0);
        count_period("duty31_sat", 16);
        offer(5'd5, 5'd5, waits);
        tick_to(4'd0);

        // Mid-period updates: 12 accepted at CNT=3, 7 held off until the wrap cycle.
        highs = 0;
        tick_to(4'd3);
        offer(5'd12, 5'd12, waits);
        check("mid_offer_waits", waits, 0);
        check("ready_blocked", duty_if.DUTY_READY, 1'b0);
        offer(5'd7, 5'd7, waits);
        check("second_offer_waits", waits, 11);
        check("current_period_keeps5", highs, 5);
        check("ready_full_again", duty_if.DUTY_READY, 1'b0);
        count_period("duty12", 12);
        count_period("duty7", 7);
        check("ready_empty", duty_if.DUTY_READY, 1'b1);

        // Misaligned wrap at CNT=6.
        tick_to(4'd6);
        WRAP = 1'b1;
        #1;
        check("ready_forced_wrap", duty_if.DUTY_READY, 1'b1);
        tick();
        check("sync_err_set", SYNC_ERR, 1'b1);
        tick_to(4'd0);
        count_period("duty7_after_err", 7);
        check("sync_err_sticky", SYNC_ERR, 1'b1);

        // Asynchronous reset in the middle of a high phase.
        tick_to(4'd3);
        check("pre_reset_pwm", PWM, 1'b1);
        #2 ASYNCRESETN = 1'b0;
        #1;
        check("async_pwm", PWM, 1'b0);
        check("async_period", PERIOD_CNT, 8'd0);
        check("async_sync_err", SYNC_ERR, 1'b0);
        check("async_ready", duty_if.DUTY_READY, 1'b1);
`ifdef PWM4_COMP_EN
        check("async_pwm_n", PWM_N, 1'b0);
`endif
        clear_model();
        repeat (2) tick();
        ASYNCRESETN = 1'b1;
        tick_to(4'd0);
        count_period("resync_duty0", 0);
        offer(5'd16, 5'd16, waits);
        tick_to(4'd0);
        count_period("resync_duty16", 16);
        check("resync_period", PERIOD_CNT, 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
